// File: rtl/maj_sampler.sv
`default_nettype none
// ============================================================================
// Module      : maj_sampler
// Description : Prescaled 3-sample majority-vote filter for a noisy bit, with
//               edge pulses and a saturating count of disagreeing windows.
// Revision    : 1.0 - initial release
// ============================================================================
module maj_sampler #(
    parameter int DIV   = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             din,
    output logic             dout,
    output logic             valid,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] glitch_cnt
);

    localparam int                 c_PRE_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_PRE_W-1:0] c_PRE_MAX = c_PRE_W'(DIV - 1);
    localparam logic [c_PRE_W-1:0] c_PRE_ONE = c_PRE_W'(1);
    localparam logic [CNT_W-1:0]   c_CNT_MAX = '1;
    localparam logic [CNT_W-1:0]   c_CNT_ONE = CNT_W'(1);

    localparam logic [1:0] c_FILL0 = 2'd0;
    localparam logic [1:0] c_FILL1 = 2'd1;
    localparam logic [1:0] c_FILL2 = 2'd2;
    localparam logic [1:0] c_RUN   = 2'd3;

    logic [c_PRE_W-1:0] r_pre;
    // Only the two newest samples are kept: the oldest one is shifted out
    // on the very tick that forms the next window, so it is never read.
    logic [1:0]         r_s;
    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic               r_dout;
    logic               r_valid;
    logic               r_rise;
    logic               r_fall;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_tick;
    logic [2:0]         w_win;
    logic               w_vote;
    logic               w_load;
    logic               w_run_tick;
    logic               w_disagree;

    assign w_tick     = en && (r_pre == c_PRE_MAX);
    assign w_win      = {r_s, din};
    assign w_vote     = (w_win[0] & w_win[1]) | (w_win[0] & w_win[2]) | (w_win[1] & w_win[2]);
    assign w_run_tick = w_tick && (r_state == c_RUN);
    assign w_load     = w_tick && ((r_state == c_FILL2) || (r_state == c_RUN));
    assign w_disagree = (w_win != 3'b000) && (w_win != 3'b111);

    always_comb begin
        w_state_nxt = r_state;
        if (w_tick) begin
            case (r_state)
                c_FILL0: w_state_nxt = c_FILL1;
                c_FILL1: w_state_nxt = c_FILL2;
                c_FILL2: w_state_nxt = c_RUN;
                c_RUN:   w_state_nxt = c_RUN;
                default: w_state_nxt = c_FILL0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_FILL0;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre   <= '0;
            r_s     <= 2'b00;
            r_dout  <= 1'b0;
            r_valid <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            // Pulses are only ever raised by a RUN tick, so they drop otherwise.
            r_rise <= w_run_tick && w_vote && !r_dout;
            r_fall <= w_run_tick && !w_vote && r_dout;
            if (en) begin
                r_pre <= (r_pre == c_PRE_MAX) ? '0 : r_pre + c_PRE_ONE;
            end
            if (w_tick) begin
                r_s <= w_win[1:0];
            end
            if (w_load) begin
                r_dout  <= w_vote;
                r_valid <= 1'b1;
            end
            if (w_run_tick && w_disagree && (r_cnt != c_CNT_MAX)) begin
                r_cnt <= r_cnt + c_CNT_ONE;
            end
        end
    end

    assign dout       = r_dout;
    assign valid      = r_valid;
    assign rise       = r_rise;
    assign fall       = r_fall;
    assign glitch_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_maj_sampler.sv
`default_nettype none
// ============================================================================
// Module      : tb_maj_sampler
// Description : Self-checking bench for maj_sampler (DIV=4/CNT_W=8 and
//               DIV=1/CNT_W=2 instances).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_maj_sampler;

    localparam int DIV = 4;

    typedef struct packed {
        logic       dout;
        logic       valid;
        logic       rise;
        logic       fall;
        logic [7:0] cnt;
    } exp_t;

    typedef struct {
        logic din;
        exp_t x;
    } tvec_t;

    logic       clk = 1'b0;
    logic       rst_n, en, din;
    logic       dout, valid, rise, fall;
    logic [7:0] glitch_cnt;
    logic       rst2_n, en2, din2;
    logic       dout2, valid2, rise2, fall2;
    logic [1:0] glitch2;

    always #5 clk = ~clk;

    maj_sampler #(.DIV(DIV), .CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .din(din),
        .dout(dout), .valid(valid), .rise(rise), .fall(fall), .glitch_cnt(glitch_cnt)
    );

    maj_sampler #(.DIV(1), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst2_n), .en(en2), .din(din2),
        .dout(dout2), .valid(valid2), .rise(rise2), .fall(fall2), .glitch_cnt(glitch2)
    );

    exp_t  sb[$];
    int    n_vec = 0;
    int    n_bad = 0;
    exp_t  cur;
    tvec_t tab[20];
    exp_t  sat_tab[8];

    // Reference model state for the random phase
    int         m_pre, m_nsamp;
    logic [2:0] m_hist;
    logic       m_dout, m_valid, m_rise, m_fall;
    logic [7:0] m_glitch;

    function automatic exp_t mk(input logic o, input logic v, input logic r, input logic f, input int c);
        exp_t e;
        e.dout = o; e.valid = v; e.rise = r; e.fall = f; e.cnt = 8'(c);
        return e;
    endfunction

    function automatic tvec_t tv(input logic d, input exp_t x);
        tvec_t t;
        t.din = d; t.x = x;
        return t;
    endfunction

    task automatic check(input string nm, input exp_t act);
        exp_t e;
        n_vec++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL %s: scoreboard empty, got %h", nm, act);
        end else begin
            e = sb.pop_front();
            if (act !== e) begin
                n_bad++;
                $display("FAIL %s @%0t: got dout=%b valid=%b rise=%b fall=%b cnt=%0d, want dout=%b valid=%b rise=%b fall=%b cnt=%0d",
                         nm, $time, act.dout, act.valid, act.rise, act.fall, act.cnt,
                         e.dout, e.valid, e.rise, e.fall, e.cnt);
            end
        end
    endtask

    task automatic cyc(input logic e, input logic d, input exp_t x, input string nm);
        @(negedge clk);
        en  = e;
        din = d;
        sb.push_back(x);
        @(posedge clk);
        #1;
        check(nm, {dout, valid, rise, fall, glitch_cnt});
    endtask

    // One sample period: DIV enabled edges, only the last of which is a tick.
    task automatic tick_vec(input logic d, input exp_t x, input string nm);
        for (int i = 1; i <= DIV; i++) begin
            if (i == DIV) cyc(1'b1, d, x, nm);
            else          cyc(1'b1, d, mk(cur.dout, cur.valid, 1'b0, 1'b0, int'(cur.cnt)), nm);
        end
        cur = x;
    endtask

    task automatic model_edge(input logic e, input logic d);
        logic [2:0] w;
        int         ones;
        logic       maj;
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (e) begin
            if (m_pre == DIV - 1) begin
                m_pre = 0;
                w     = {m_hist[1:0], d};
                ones  = int'(w[0]) + int'(w[1]) + int'(w[2]);
                maj   = (ones >= 2);
                if (m_nsamp >= 2) begin
                    if (m_nsamp >= 3) begin
                        m_rise = maj & ~m_dout;
                        m_fall = ~maj & m_dout;
                        if ((ones == 1 || ones == 2) && m_glitch != 8'hFF) m_glitch = m_glitch + 8'd1;
                    end
                    m_dout  = maj;
                    m_valid = 1'b1;
                end
                m_hist = w;
                if (m_nsamp < 3) m_nsamp++;
            end else begin
                m_pre++;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        en    = 1'b0;
        din   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cur   = mk(0, 0, 0, 0, 0);
    endtask

    initial begin
        // din, then expected dout/valid/rise/fall/glitch_cnt after that tick
        tab[0]  = tv(1, mk(0, 0, 0, 0, 0));
        tab[1]  = tv(1, mk(0, 0, 0, 0, 0));
        tab[2]  = tv(1, mk(1, 1, 0, 0, 0));
        tab[3]  = tv(0, mk(1, 1, 0, 0, 1));
        tab[4]  = tv(0, mk(0, 1, 0, 1, 2));
        tab[5]  = tv(0, mk(0, 1, 0, 0, 2));
        tab[6]  = tv(1, mk(0, 1, 0, 0, 3));
        tab[7]  = tv(0, mk(0, 1, 0, 0, 4));
        tab[8]  = tv(0, mk(0, 1, 0, 0, 5));
        tab[9]  = tv(0, mk(0, 1, 0, 0, 5));
        tab[10] = tv(1, mk(0, 1, 0, 0, 6));
        tab[11] = tv(1, mk(1, 1, 1, 0, 7));
        tab[12] = tv(1, mk(1, 1, 0, 0, 7));
        tab[13] = tv(1, mk(1, 1, 0, 0, 7));
        tab[14] = tv(0, mk(1, 1, 0, 0, 8));
        tab[15] = tv(0, mk(0, 1, 0, 1, 9));
        tab[16] = tv(0, mk(0, 1, 0, 0, 9));
        tab[17] = tv(1, mk(0, 1, 0, 0, 10));
        tab[18] = tv(1, mk(1, 1, 1, 0, 11));
        tab[19] = tv(1, mk(1, 1, 0, 0, 11));

        sat_tab[0] = mk(0, 0, 0, 0, 0);
        sat_tab[1] = mk(0, 0, 0, 0, 0);
        sat_tab[2] = mk(0, 1, 0, 0, 0);
        sat_tab[3] = mk(1, 1, 1, 0, 1);
        sat_tab[4] = mk(0, 1, 0, 1, 2);
        sat_tab[5] = mk(1, 1, 1, 0, 3);
        sat_tab[6] = mk(0, 1, 0, 1, 3);
        sat_tab[7] = mk(1, 1, 1, 0, 3);

        rst_n = 1'b0; en = 1'b0; din = 1'b1;
        rst2_n = 1'b0; en2 = 1'b0; din2 = 1'b0;
        #12;
        sb.push_back(mk(0, 0, 0, 0, 0));
        check("reset_state", {dout, valid, rise, fall, glitch_cnt});

        // Fill, single glitch, steps up and down
        do_reset();
        for (int i = 0; i < 20; i++) tick_vec(tab[i].din, tab[i].x, $sformatf("tick%0d", i + 1));

        // Asynchronous reset between edges while dout=1
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        en    = 1'b0;
        #1;
        sb.push_back(mk(0, 0, 0, 0, 0));
        check("async_reset", {dout, valid, rise, fall, glitch_cnt});
        #1;
        rst_n = 1'b1;

        // Refill with an enable pause right after the FILL1 tick
        for (int i = 0; i < 8; i++)  cyc(1'b1, 1'b1, mk(0, 0, 0, 0, 0), "refill_a");
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, mk(0, 0, 0, 0, 0), "en_hold");
        for (int i = 0; i < 3; i++)  cyc(1'b1, 1'b1, mk(0, 0, 0, 0, 0), "refill_b");
        cyc(1'b1, 1'b1, mk(1, 1, 0, 0, 0), "refill_done");

        // Random run against the reference model
        do_reset();
        m_pre = 0; m_nsamp = 0; m_hist = 3'b000;
        m_dout = 0; m_valid = 0; m_rise = 0; m_fall = 0; m_glitch = 8'd0;
        begin
            logic e, d;
            d = 1'b0;
            for (int i = 0; i < 400; i++) begin
                e = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 2) == 0) d = ~d;
                model_edge(e, d);
                cyc(e, d, mk(m_dout, m_valid, m_rise, m_fall, int'(m_glitch)), "random");
            end
        end

        // DIV=1, CNT_W=2: tick every cycle, counter saturates at 3
        @(negedge clk);
        rst2_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            en2  = 1'b1;
            din2 = (k % 2 == 0);
            sb.push_back(sat_tab[k - 1]);
            @(posedge clk);
            #1;
            check($sformatf("sat%0d", k), {dout2, valid2, rise2, fall2, 6'b0, glitch2});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
